execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EX stage of the 5-stage MIPS-style pipeline, between ID/EX and MEM.
//  Selects ALU operand B, decodes the ALU operation, selects the destination register.
//  Registers result, store data, destination, jump address and zero flag into the EX/MEM latch.
// PARAMETERS
//  none; datapath 32 bit, register index 5 bit, jump address 11 bit (fixed)
// PORTS
//  clock              in   1   pipeline clock, rising edge
//  reset              in   1   asynchronous, active-low; clears EX/MEM latch
//  ALUSrc             in   1   0: B=registro_2, 1: B=sign_extend
//  RegDst             in   1   1: dest=reg_dest_r_type, 0: dest=reg_dest_l_type
//  ALUOp              in   1   0: add (load/store/addi), 1: R-type, decode funct
//  registro_1         in   32  rs value, operand A
//  registro_2         in   32  rt value, operand B / store data
//  sign_extend        in   32  sign-extended immediate; [5:0]=funct, [10:6]=shamt
//  jump_dest_addr     in   11  branch/jump target, passed through
//  reg_dest_r_type    in   5   rd field
//  reg_dest_l_type    in   5   rt field
//  result_out         out  32  registered ALU result
//  registro_2_out     out  32  registered registro_2 (store data)
//  reg_dest_out       out  5   registered selected destination
//  jump_dest_addr_out out  11  registered jump_dest_addr
//  zero_signal_out    out  1   registered (ALU result == 0)
// BEHAVIOUR
//  - reset low (any time, async): all outputs 0 immediately; held while low
//  - all outputs update only on rising clock edge; latency 1 cycle; no handshake, no stall
//  - A=registro_1; B = ALUSrc ? sign_extend : registro_2 (combinational)
//  - ALUOp=0: result = A+B, mod 2^32, carry discarded
//  - ALUOp=1, funct=sign_extend[5:0]:
//    0x20/0x21 A+B; 0x22/0x23 A-B; 0x24 A&B; 0x25 A|B; 0x26 A^B; 0x27 ~(A|B)
//    0x2A signed A<B ? 1:0; 0x2B unsigned A<B ? 1:0
//    0x00 B<<shamt; 0x02 B>>shamt logical; 0x03 B>>>shamt arithmetic
//    0x04 B<<A[4:0]; 0x06 B>>A[4:0] logical; 0x07 B>>>A[4:0] arithmetic
//    any other funct: A+B
//  - shamt = sign_extend[10:6]; shift counts use 5 LSBs only
//  - zero_signal_out = (next result_out == 0), same edge as result_out
//  - registro_2_out always gets registro_2, independent of ALUSrc
//  - reg_dest_out = RegDst ? reg_dest_r_type : reg_dest_l_type
//  - no overflow trap; signed wrap-around silent (unless EXECUTE_OVF_EN)
// CONFIGURATION
//  EXECUTE_OVF_EN defined: extra port overflow_out out 1, registered.
//    Set when funct 0x20 (add) or 0x22 (sub) overflows signed, with ALUOp=1.
//    Also set for ALUOp=0 add overflow. Cleared by reset and on every non-overflow cycle.
//  EXECUTE_OVF_EN undefined: port absent; overflow ignored; results identical.
// TESTING
//  1 reset=0 mid-run with nonzero outputs -> all outputs 0 without a clock edge
//  2 A=2, rt=2, imm=4, ALUSrc=0, ALUOp=0 -> next edge result_out=4, zero=0, registro_2_out=2
//  3 same, ALUOp=1 (funct 0x04, sllv) -> result_out=8; then ALUSrc=1 -> 4<<2=16
//  4 ALUSrc=1, ALUOp=0, A=2, imm=4 -> result_out=6; jump_dest_addr=0x7FF -> out 0x7FF
//  5 ALUOp=1, funct 0x22, A=B=5 -> result_out=0, zero=1
//    funct 0x2A, A=-1, B=1 -> result_out=1
//  6 RegDst=1, rd=9, rt=3 -> reg_dest_out=9; RegDst=0 -> 3
//    EXECUTE_OVF_EN: 0x7FFFFFFF+1 -> overflow_out=1

Source files
------------

// File: rtl/execute_stage.sv
// EX stage: operand-B mux, ALU/funct decode, destination select and EX/MEM latch.
// Optional build macro EXECUTE_OVF_EN adds a registered signed-overflow flag.
module execute_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        ALUSrc,
  input  logic        RegDst,
  input  logic        ALUOp,
  input  logic [31:0] registro_1,
  input  logic [31:0] registro_2,
  input  logic [31:0] sign_extend,
  input  logic [10:0] jump_dest_addr,
  input  logic [4:0]  reg_dest_r_type,
  input  logic [4:0]  reg_dest_l_type,
  output logic [31:0] result_out,
  output logic [31:0] registro_2_out,
  output logic [4:0]  reg_dest_out,
  output logic [10:0] jump_dest_addr_out,
  output logic        zero_signal_out
`ifdef EXECUTE_OVF_EN
  ,
  output logic        overflow_out
`endif
);

  logic [31:0] a, b, sum, diff, alu;
  logic [5:0]  funct;
  logic [4:0]  shamt, vshamt;
  logic        add_ovf, sub_ovf, ovf;

  assign a      = registro_1;
  assign b      = ALUSrc ? sign_extend : registro_2;
  assign funct  = sign_extend[5:0];
  assign shamt  = sign_extend[10:6];
  assign vshamt = a[4:0];
  assign sum    = a + b;
  assign diff   = a - b;

  // Signed overflow: operands agree (add) / differ (sub) in sign but result flips.
  assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);

  always_comb begin
    alu = sum;
    ovf = 1'b0;
    if (!ALUOp) begin
      ovf = add_ovf;
    end else begin
      case (funct)
        6'h20: begin alu = sum;  ovf = add_ovf; end
        6'h21: alu = sum;
        6'h22: begin alu = diff; ovf = sub_ovf; end
        6'h23: alu = diff;
        6'h24: alu = a & b;
        6'h25: alu = a | b;
        6'h26: alu = a ^ b;
        6'h27: alu = ~(a | b);
        6'h2A: alu = {31'd0, ($signed(a) < $signed(b))};
        6'h2B: alu = {31'd0, (a < b)};
        6'h00: alu = b << shamt;
        6'h02: alu = b >> shamt;
        6'h03: alu = $signed(b) >>> shamt;
        6'h04: alu = b << vshamt;
        6'h06: alu = b >> vshamt;
        6'h07: alu = $signed(b) >>> vshamt;
        default: alu = sum;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_out         <= '0;
      registro_2_out     <= '0;
      reg_dest_out       <= '0;
      jump_dest_addr_out <= '0;
      zero_signal_out    <= 1'b0;
    end else begin
      result_out         <= alu;
      registro_2_out     <= registro_2;
      reg_dest_out       <= RegDst ? reg_dest_r_type : reg_dest_l_type;
      jump_dest_addr_out <= jump_dest_addr;
      zero_signal_out    <= (alu == 32'd0);
    end
  end

`ifdef EXECUTE_OVF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) overflow_out <= 1'b0;
    else        overflow_out <= ovf;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage (EXECUTE_OVF_EN checks when defined).
module tb_execute_stage;
  logic        clock, reset, ALUSrc, RegDst, ALUOp;
  logic [31:0] registro_1, registro_2, sign_extend;
  logic [10:0] jump_dest_addr;
  logic [4:0]  reg_dest_r_type, reg_dest_l_type;
  logic [31:0] result_out, registro_2_out;
  logic [4:0]  reg_dest_out;
  logic [10:0] jump_dest_addr_out;
  logic        zero_signal_out;
`ifdef EXECUTE_OVF_EN
  logic        overflow_out;
`endif
  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clock(clock), .reset(reset), .ALUSrc(ALUSrc), .RegDst(RegDst), .ALUOp(ALUOp),
    .registro_1(registro_1), .registro_2(registro_2), .sign_extend(sign_extend),
    .jump_dest_addr(jump_dest_addr), .reg_dest_r_type(reg_dest_r_type),
    .reg_dest_l_type(reg_dest_l_type), .result_out(result_out),
    .registro_2_out(registro_2_out), .reg_dest_out(reg_dest_out),
    .jump_dest_addr_out(jump_dest_addr_out), .zero_signal_out(zero_signal_out)
`ifdef EXECUTE_OVF_EN
    , .overflow_out(overflow_out)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic src, input logic op, input logic [31:0] ra,
                      input logic [31:0] rb, input logic [31:0] imm);
    @(negedge clock);
    ALUSrc = src; ALUOp = op; registro_1 = ra; registro_2 = rb; sign_extend = imm;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; ALUSrc = 0; RegDst = 0; ALUOp = 0;
    registro_1 = 0; registro_2 = 0; sign_extend = 0; jump_dest_addr = 0;
    reg_dest_r_type = 0; reg_dest_l_type = 0;
    #12;
    checks++;
    if ({result_out, registro_2_out, reg_dest_out, jump_dest_addr_out, zero_signal_out} !== 81'd0) begin
      errors++; $display("FAIL reset_state got %h expected 0",
        {result_out, registro_2_out, reg_dest_out, jump_dest_addr_out, zero_signal_out});
    end
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_add;
    jump_dest_addr = 11'h7FF;
    step(0, 0, 32'd2, 32'd2, 32'd4);
    checks++;
    if (result_out !== 32'd4) begin errors++; $display("FAIL add_reg got %h expected 4", result_out); end
    checks++;
    if (zero_signal_out !== 1'b0) begin errors++; $display("FAIL add_reg_zero got %b expected 0", zero_signal_out); end
    checks++;
    if (registro_2_out !== 32'd2) begin errors++; $display("FAIL store_data got %h expected 2", registro_2_out); end
    step(1, 0, 32'd2, 32'd2, 32'd4);
    checks++;
    if (result_out !== 32'd6) begin errors++; $display("FAIL add_imm got %h expected 6", result_out); end
    checks++;
    if (registro_2_out !== 32'd2) begin errors++; $display("FAIL store_data_imm got %h expected 2", registro_2_out); end
    checks++;
    if (jump_dest_addr_out !== 11'h7FF) begin errors++; $display("FAIL jump_addr got %h expected 7ff", jump_dest_addr_out); end
  endtask

  task automatic test_sllv;
    step(0, 1, 32'd2, 32'd2, 32'd4);
    checks++;
    if (result_out !== 32'd8) begin errors++; $display("FAIL sllv_reg got %h expected 8", result_out); end
    step(1, 1, 32'd2, 32'd2, 32'd4);
    checks++;
    if (result_out !== 32'd16) begin errors++; $display("FAIL sllv_imm got %h expected 16", result_out); end
  endtask

  task automatic test_funct;
    logic [31:0] va [15] = '{32'd5, 32'hFFFFFFFF, 32'hF0F01234, 32'hF0F01234, 32'hF0F01234, 32'hF0F01234,
                             32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'h21, 32'h3F, 32'd0, 32'd3};
    logic [31:0] vb [15] = '{32'd5, 32'd1, 32'h0FF0FF00, 32'h0FF0FF00, 32'h0FF0FF00, 32'h0FF0FF00,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 32'h80000010, 32'h80000010,
                             32'h80000000, 32'h80000000, 32'd1, 32'd4};
    logic [31:0] vi [15] = '{32'h22, 32'h2A, 32'h24, 32'h25, 32'h26, 32'h27, 32'h2B, 32'h2A,
                             32'h100, 32'h102, 32'h103, 32'h07, 32'h06, 32'h23, 32'h3F};
    logic [31:0] ve [15] = '{32'd0, 32'd1, 32'h00F01200, 32'hFFF0FF34, 32'hFF00ED34, 32'h000F00CB,
                             32'd1, 32'd0, 32'h00000010, 32'h08000001, 32'hF8000001,
                             32'hC0000000, 32'd1, 32'hFFFFFFFF, 32'd7};
    for (int i = 0; i < 15; i++) begin
      step(0, 1, va[i], vb[i], vi[i]);
      checks++;
      if (result_out !== ve[i]) begin
        errors++; $display("FAIL funct_%0d_result got %h expected %h", i, result_out, ve[i]);
      end
      checks++;
      if (zero_signal_out !== (ve[i] == 32'd0)) begin
        errors++; $display("FAIL funct_%0d_zero got %b expected %b", i, zero_signal_out, ve[i] == 32'd0);
      end
    end
  endtask

  task automatic test_regdst;
    @(negedge clock); reg_dest_r_type = 5'd9; reg_dest_l_type = 5'd3; RegDst = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (reg_dest_out !== 5'd9) begin errors++; $display("FAIL regdst_rd got %0d expected 9", reg_dest_out); end
    @(negedge clock); RegDst = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (reg_dest_out !== 5'd3) begin errors++; $display("FAIL regdst_rt got %0d expected 3", reg_dest_out); end
  endtask

  task automatic test_overflow;
    step(0, 0, 32'h7FFFFFFF, 32'd1, 32'd0);
    checks++;
    if (result_out !== 32'h80000000) begin errors++; $display("FAIL wrap_add got %h expected 80000000", result_out); end
`ifdef EXECUTE_OVF_EN
    checks++;
    if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_add got %b expected 1", overflow_out); end
    step(0, 1, 32'h80000000, 32'd1, 32'h22);
    checks++;
    if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_sub got %b expected 1", overflow_out); end
    step(0, 1, 32'h7FFFFFFF, 32'd1, 32'h21);
    checks++;
    if (overflow_out !== 1'b0) begin errors++; $display("FAIL ovf_addu got %b expected 0", overflow_out); end
`endif
  endtask

  task automatic test_async_reset;
    step(0, 0, 32'd7, 32'd9, 32'd0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({result_out, registro_2_out, reg_dest_out, jump_dest_addr_out, zero_signal_out} !== 81'd0) begin
      errors++; $display("FAIL async_reset got %h expected 0",
        {result_out, registro_2_out, reg_dest_out, jump_dest_addr_out, zero_signal_out});
    end
    @(posedge clock); #1;
    checks++;
    if (result_out !== 32'd0) begin errors++; $display("FAIL reset_hold got %h expected 0", result_out); end
    @(negedge clock); reset = 1'b1;
    step(0, 0, 32'd7, 32'd9, 32'd0);
    checks++;
    if (result_out !== 32'd16) begin errors++; $display("FAIL post_reset got %h expected 16", result_out); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sllv;
    test_funct;
    test_regdst;
    test_overflow;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
